sr_cmd_gen: RTL

Command front-end placed directly upstream of `srff`: converts two raw, asynchronous, possibly bouncing request lines (set and clear) into clean, synchronous, fixed-width `s`/`r` pulses. Guarantees `srff` never sees `{s,r}=2'b11`, and always sees at least one idle `2'b00` cycle between consecutive commands. Outputs connect one-to-one to `srff.s`/`srff.r` on the same `clk`.

---
 rtl/sr_cmd_if.sv | 13 +
 rtl/sr_cmd_gen.sv | 117 +++++++++++
 2 files changed

// File: rtl/sr_cmd_if.sv
// Request/command bundle between the raw request source and sr_cmd_gen.
// The master drives the raw requests; the slave returns the s/r pulses and status.
interface sr_cmd_if;
    logic set_req;
    logic clr_req;
    logic s;
    logic r;
    logic busy;
    logic conflict;

    modport master (output set_req, clr_req, input s, r, busy, conflict);
    modport slave  (input set_req, clr_req, output s, r, busy, conflict);
endinterface

// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen: synchronizes and debounces set/clear requests into clean, spaced s/r pulses for srff.
// Build option SR_CLR_PRIORITY_EN: on a simultaneous set/clear request, clear wins instead of both being dropped.
//
// state | meaning
// IDLE  | waiting; takes event-or-pending requests
// SET   | s high for PULSE_LEN cycles
// CLR   | r high for PULSE_LEN cycles
// GAP   | one idle 2'b00 cycle before returning to IDLE
module sr_cmd_gen #(
    parameter int DEB_CYCLES = 4,
    parameter int PULSE_LEN  = 2,
    parameter int CNT_W      = 8
) (
    input  logic    clk,
    input  logic    rst_n,
    sr_cmd_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SET, CLR, GAP} state_t;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] PUL_LAST = CNT_W'(PULSE_LEN - 1);
`ifdef SR_CLR_PRIORITY_EN
    localparam bit CLR_WINS = 1'b1;
`else
    localparam bit CLR_WINS = 1'b0;
`endif

    // Bit 0 is the set channel, bit 1 the clear channel.
    logic [1:0]       sync1, sync2, deb, deb_d, ev, pend, eff;
    logic [CNT_W-1:0] deb_cnt [2];
    logic [CNT_W-1:0] pcnt;
    state_t           state, state_nx;
    logic             s_q, r_q, busy_q, conflict_q;
    logic             s_nx, r_nx, busy_nx, conflict_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= '0;
            sync2      <= '0;
            deb        <= '0;
            deb_d      <= '0;
            ev         <= '0;
            deb_cnt[0] <= '0;
            deb_cnt[1] <= '0;
        end else begin
            sync1 <= {bus.clr_req, bus.set_req};
            sync2 <= sync1;
            deb_d <= deb;
            ev    <= deb & ~deb_d;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb_cnt[i] <= '0;
                    deb[i]     <= sync2[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign eff = ev | pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pcnt       <= '0;
            pend       <= '0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            busy_q     <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state      <= state_nx;
            s_q        <= s_nx;
            r_q        <= r_nx;
            busy_q     <= busy_nx;
            conflict_q <= conflict_nx;
            // IDLE always services or discards whatever is pending.
            pend       <= (state == IDLE) ? 2'b00 : (pend | ev);
            if ((state == SET || state == CLR) && state_nx == state)
                pcnt <= pcnt + 1'b1;
            else
                pcnt <= '0;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                unique case (eff)
                    2'b01:   state_nx = SET;
                    2'b10:   state_nx = CLR;
                    2'b11:   state_nx = CLR_WINS ? CLR : IDLE;
                    default: state_nx = IDLE;
                endcase
            end
            SET, CLR: if (pcnt == PUL_LAST) state_nx = GAP;
            GAP:      state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_comb begin
        s_nx        = (state_nx == SET);
        r_nx        = (state_nx == CLR);
        busy_nx     = (state_nx != IDLE);
        conflict_nx = (state == IDLE) && (eff == 2'b11);
    end

    assign bus.s        = s_q;
    assign bus.r        = r_q;
    assign bus.busy     = busy_q;
    assign bus.conflict = conflict_q;
endmodule
